// File: rtl/serial_paralelo.sv
// serial_paralelo: serial-to-parallel receiver, far end of the parallel-to-serial link.
//
// Samples one serial bit per clk_8f and hunts bit by bit for the COM idle symbol.
// When it finds one, it aligns byte boundaries to that symbol.
// After SYNC_COUNT consecutive aligned COMs the link is declared active.
// From then on every non-COM symbol is emitted as a parallel byte with a valid flag.
//
// Ports
//   clk_8f     in   1      bit clock, all logic on posedge
//   reset      in   1      asynchronous, active-low reset
//   data_in    in   1      serial bit, MSB of each symbol first
//   data_out   out  WIDTH  last received data byte
//   valid_out  out  1      data_out holds a fresh data byte for this symbol period
//   active     out  1      byte alignment achieved and confirmed (sticky until reset)
module serial_paralelo #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] COM        = 8'hBC,
  parameter int unsigned      SYNC_COUNT = 4
) (
  input  logic             clk_8f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ComW = $clog2(SYNC_COUNT + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StBuscar, StAlinear, StActivo} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ComW-1:0]  com_cnt_q, com_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             active_q, active_d;

  logic [WIDTH-1:0] sym;
  logic             is_com;
  logic             at_boundary;
  logic [CntW-1:0]  bit_cnt_inc;
  logic [ComW-1:0]  com_cnt_inc;

  // The candidate symbol includes the bit being sampled on this edge,
  // so decisions land on the same edge as the symbol's last bit.
  assign sym         = {sr_q[WIDTH-2:0], data_in};
  assign is_com      = (sym == COM);
  assign at_boundary = (bit_cnt_q == LastBit);
  assign bit_cnt_inc = at_boundary ? '0 : bit_cnt_q + CntW'(1);
  assign com_cnt_inc = com_cnt_q + ComW'(1);

  always_comb begin
    state_d   = state_q;
    sr_d      = sym;
    bit_cnt_d = bit_cnt_q;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    active_d  = active_q;

    unique case (state_q)
      StBuscar: begin
        if (is_com) begin
          bit_cnt_d = '0;
          com_cnt_d = ComW'(1);
          state_d   = StAlinear;
        end
      end

      StAlinear: begin
        bit_cnt_d = bit_cnt_inc;
        if (at_boundary) begin
          if (is_com) begin
            com_cnt_d = com_cnt_inc;
            if (com_cnt_inc == ComW'(SYNC_COUNT)) begin
              active_d = 1'b1;
              state_d  = StActivo;
            end
          end else begin
            // Misaligned or broken COM run: drop the partial count and hunt again.
            com_cnt_d = '0;
            state_d   = StBuscar;
          end
        end
      end

      StActivo: begin
        // Alignment is locked here; only boundary symbols are ever examined.
        bit_cnt_d = bit_cnt_inc;
        if (at_boundary) begin
          if (is_com) begin
            valid_d = 1'b0;
          end else begin
            data_d  = sym;
            valid_d = 1'b1;
          end
        end
      end

      default: state_d = StBuscar;
    endcase
  end

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state_q   <= StBuscar;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;

endmodule
